// File: rtl/task_mode_arbiter_if.sv
// Handshake bundle between the task arbiter and its surroundings: switch requests,
// strobes and task colours in, selection and pixel colour out.
interface task_mode_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic            tick;
    logic [N-1:0]    req;
    logic            frame_begin;
    logic [16*N-1:0] colour_in;
    logic [15:0]     default_colour;

    logic [N-1:0]    active_onehot;
    logic [IW-1:0]   active_idx;
    logic            any_active;
    logic            seg_en;
    logic            blanking;
    logic [15:0]     oled_colour;

    modport master (
        output tick, req, frame_begin, colour_in, default_colour,
        input  active_onehot, active_idx, any_active, seg_en, blanking, oled_colour
    );

    modport slave (
        input  tick, req, frame_begin, colour_in, default_colour,
        output active_onehot, active_idx, any_active, seg_en, blanking, oled_colour
    );
endinterface

// File: rtl/task_mode_arbiter.sv
// Picks one of N display tasks from debounced switches (lowest index wins) and
// blanks the OLED for a number of frames whenever the selection changes.
module task_mode_arbiter #(
    parameter int          N              = 4,
    parameter int          DEBOUNCE_TICKS = 16,
    parameter int          BLANK_FRAMES   = 2,
    parameter logic [15:0] BLANK_COLOUR   = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    task_mode_arbiter_if.slave   bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int FW = $clog2(BLANK_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, RUN, BLANK} state_t;

    logic [N-1:0]  sync1, sync2, stable;
    logic [CW-1:0] cnt [N];

    // NOTE: the per-channel counters are ordinary flops, not RAM, so they take the async reset too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int k = 0; k < N; k++) cnt[k] <= '0;
        end else begin
            sync1 <= bus.req;
            sync2 <= sync1;
            if (bus.tick) begin
                for (int k = 0; k < N; k++) begin
                    if (sync2[k] != stable[k]) begin
                        if (cnt[k] == CW'(DEBOUNCE_TICKS - 1)) begin
                            stable[k] <= ~stable[k];
                            cnt[k]    <= '0;
                        end else begin
                            cnt[k] <= cnt[k] + 1'b1;
                        end
                    end else begin
                        cnt[k] <= '0;
                    end
                end
            end
        end
    end

    logic [N-1:0]  cand_onehot;
    logic [IW-1:0] cand_idx;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        cand_onehot = '0;
        cand_idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (stable[k]) begin
                cand_onehot    = '0;
                cand_onehot[k] = 1'b1;
                cand_idx       = IW'(k);
            end
        end
    end

    state_t        state;
    logic [FW-1:0] frames_left;

    // A new candidate always wins over a coincident frame_begin, restarting the blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            frames_left       <= '0;
            bus.active_onehot <= '0;
            bus.active_idx    <= '0;
            bus.any_active    <= 1'b0;
            bus.seg_en        <= 1'b1;
            bus.blanking      <= 1'b0;
        end else if (cand_onehot != bus.active_onehot) begin
            state             <= BLANK;
            frames_left       <= FW'(BLANK_FRAMES);
            bus.active_onehot <= cand_onehot;
            bus.active_idx    <= cand_idx;
            bus.any_active    <= |cand_onehot;
            bus.seg_en        <= ~|cand_onehot;
            bus.blanking      <= 1'b1;
        end else if (state == BLANK && bus.frame_begin) begin
            if (frames_left == FW'(1)) begin
                state        <= bus.any_active ? RUN : IDLE;
                frames_left  <= '0;
                bus.blanking <= 1'b0;
            end else begin
                frames_left <= frames_left - 1'b1;
            end
        end
    end

    always_comb begin
        bus.oled_colour = bus.default_colour;
        case (state)
            BLANK: bus.oled_colour = BLANK_COLOUR;
            RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (bus.active_idx == IW'(k)) bus.oled_colour = bus.colour_in[16*k +: 16];
                end
            end
            default: bus.oled_colour = bus.default_colour;
        endcase
    end
endmodule

// File: tb/tb_task_mode_arbiter.sv
// Directed bench for task_mode_arbiter: a cycle model built from the selection
// rules is compared every cycle, plus hand-computed literal checkpoints.
module tb_task_mode_arbiter;
    localparam int N         = 4;
    localparam int DB        = 16;
    localparam int BF        = 2;
    localparam int TICK_DIV  = 4;
    localparam int FRAME_DIV = 7;
    localparam logic [15:0] DEF = 16'hF800;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    task_mode_arbiter_if #(.N(N)) bus ();

    task_mode_arbiter #(
        .N(N), .DEBOUNCE_TICKS(DB), .BLANK_FRAMES(BF), .BLANK_COLOUR(16'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: sync delay as a two-deep history, debounce as run lengths,
    // selection as an integer (-1 = none) and blank as frames remaining.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0;
    int m_run [N];
    int m_sel   = -1;
    int m_blank = 0;
    int m_cand;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0;
            for (int k = 0; k < N; k++) m_run[k] = 0;
            m_sel = -1; m_blank = 0;
        end else begin
            m_cand = -1;
            for (int k = N - 1; k >= 0; k--) if (m_stable[k]) m_cand = k;
            if (m_cand != m_sel) begin
                m_sel = m_cand;
                m_blank = BF;
            end else if (m_blank > 0 && bus.frame_begin) begin
                m_blank--;
            end
            if (bus.tick) begin
                for (int k = 0; k < N; k++) begin
                    if (m_s2[k] != m_stable[k]) begin
                        m_run[k]++;
                        if (m_run[k] == DB) begin
                            m_stable[k] = ~m_stable[k];
                            m_run[k] = 0;
                        end
                    end else begin
                        m_run[k] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = bus.req;
        end
    end

    bit saw_blank = 0;
    logic [15:0] exp_colour;

    always @(negedge clk) begin
        if (!reset) begin
            if (m_blank > 0)     exp_colour = 16'h0000;
            else if (m_sel >= 0) exp_colour = bus.colour_in[16*m_sel +: 16];
            else                 exp_colour = bus.default_colour;
            check("m_active_onehot", bus.active_onehot, (m_sel < 0) ? 0 : (1 << m_sel));
            check("m_active_idx", bus.active_idx, (m_sel < 0) ? 0 : m_sel);
            check("m_any_active", bus.any_active, m_sel >= 0);
            check("m_seg_en", bus.seg_en, m_sel < 0);
            check("m_blanking", bus.blanking, m_blank > 0);
            check("m_oled_colour", bus.oled_colour, exp_colour);
            if (bus.blanking) saw_blank = 1;
        end
    end

    int cyc = 0;
    bit frames_auto = 0;
    bit pend_frame = 0;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            cyc++;
            bus.tick        = (cyc % TICK_DIV == 0);
            bus.frame_begin = frames_auto ? (cyc % FRAME_DIV == 0) : pend_frame;
            pend_frame      = 0;
        end
    endtask

    task automatic pulse_frame();
        pend_frame = 1;
        step(2);
    endtask

    task automatic wait_sel(input logic [N-1:0] want, input int budget, input string name,
                            output int took);
        took = 0;
        while (bus.active_onehot !== want && took < budget) begin
            step(1);
            took++;
        end
        check(name, bus.active_onehot, want);
    endtask

    int took;
    int nframes;

    initial begin
        bus.tick           = 0;
        bus.req            = '0;
        bus.frame_begin    = 0;
        bus.colour_in      = {16'h001F, 16'h07E0, 16'h2222, 16'h1111};
        bus.default_colour = DEF;
        step(3);
        reset = 0;

        // Idle after 40 ticks with no request
        step(160);
        check("idle_onehot", bus.active_onehot, 0);
        check("idle_seg_en", bus.seg_en, 1);
        check("idle_colour", bus.oled_colour, 16'hF800);
        check("idle_blanking", bus.blanking, 0);

        // Acquire channel 2: 2 clk sync + 16 ticks, then 2-frame blank
        bus.req = 4'b0100;
        wait_sel(4'b0100, 100, "acq_ch2", took);
        check("acq_ch2_latency", (took >= 64 && took <= 67), 1);
        check("acq_ch2_seg_en", bus.seg_en, 0);
        check("acq_ch2_blank", bus.blanking, 1);
        check("acq_ch2_black", bus.oled_colour, 16'h0000);
        pulse_frame();
        check("ch2_blank_after_1", bus.blanking, 1);
        check("ch2_black_after_1", bus.oled_colour, 16'h0000);
        pulse_frame();
        check("ch2_blank_done", bus.blanking, 0);
        check("ch2_colour", bus.oled_colour, 16'h07E0);

        // Priority: channel 1 beats channel 2, dropping it returns to 2
        bus.req = 4'b0110;
        wait_sel(4'b0010, 100, "pri_ch1", took);
        pulse_frame();
        pulse_frame();
        check("ch1_colour", bus.oled_colour, 16'h2222);
        bus.req = 4'b0100;
        wait_sel(4'b0100, 100, "back_ch2", took);
        check("back_ch2_blank", bus.blanking, 1);
        pulse_frame();
        pulse_frame();
        check("back_ch2_colour", bus.oled_colour, 16'h07E0);

        // Release to idle, then glitches on channel 3 with free-running frames
        bus.req = 4'b0000;
        wait_sel(4'b0000, 100, "release_all", took);
        pulse_frame();
        pulse_frame();
        check("release_blank_done", bus.blanking, 0);
        frames_auto = 1;
        saw_blank = 0;
        bus.req = 4'b1000;
        step(40);
        bus.req = 4'b0000;
        step(120);
        check("glitch10_no_blank", saw_blank, 0);
        check("glitch10_no_sel", bus.active_onehot, 0);
        bus.req = 4'b1000;
        step(64);
        bus.req = 4'b0000;
        wait_sel(4'b1000, 100, "glitch16_accept", took);
        wait_sel(4'b0000, 200, "glitch16_release", took);
        step(40);
        frames_auto = 0;

        // Change 2 -> 3 after one blank frame: reload gives 3 frames in total
        bus.req = 4'b0100;
        wait_sel(4'b0100, 100, "ch2_again", took);
        pulse_frame();
        check("ch2_again_one_frame", bus.blanking, 1);
        bus.req = 4'b1000;
        wait_sel(4'b1000, 100, "switch_ch3", took);
        check("switch_ch3_idx", bus.active_idx, 3);
        check("switch_ch3_blank", bus.blanking, 1);
        nframes = 1;
        while (bus.blanking && nframes < 10) begin
            pulse_frame();
            nframes++;
        end
        check("total_blank_frames", nframes, 3);
        check("ch3_colour", bus.oled_colour, 16'h001F);

        // Reset in the middle of a blank with channel 0 selected
        bus.req = 4'b0001;
        wait_sel(4'b0001, 100, "sel_ch0", took);
        check("ch0_blanking", bus.blanking, 1);
        #1;
        reset = 1;
        #1;
        check("rst_onehot", bus.active_onehot, 0);
        check("rst_blanking", bus.blanking, 0);
        check("rst_seg_en", bus.seg_en, 1);
        check("rst_colour", bus.oled_colour, 16'hF800);
        step(2);
        reset = 0;
        wait_sel(4'b0001, 100, "reacquire_ch0", took);
        check("reacquire_latency", (took >= 64 && took <= 67), 1);
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/task_mode_arbiter.md
Name: task_mode_arbiter

Overview:
- Parametrised successor to the top-level subtask switching logic: selects one of N display tasks from switch requests and drives the OLED colour mux, task LEDs and the 7-segment enable.
- Adds per-channel switch synchronisation and debounce, and a fixed priority of lowest index wins.
- Adds a blanking interval counted in OLED frames on every task change, so the panel never shows a torn mix of two tasks.
- Sits between the sw inputs and task colour outputs on one side, and Oled_Display pixel_data, led[] and SevenSeg_Control en on the other.

Parameters:
- N, 4, number of task channels (N >= 2).
- DEBOUNCE_TICKS, 16, consecutive tick samples a request must hold at one level before it is accepted (>= 1).
- BLANK_FRAMES, 2, frame_begin pulses for which the output is forced black after a selection change (>= 1).
- BLANK_COLOUR, 16'h0000, RGB565 value driven during blanking.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  single-cycle sample strobe (10 kHz), synchronous to clk.
- req  in  N  raw task request switches, asynchronous; bit 0 has highest priority.
- frame_begin  in  1  single-cycle pulse from the OLED driver, synchronous to clk.
- colour_in  in  16*N  packed task colours; channel k occupies bits [16k+15:16k].
- default_colour  in  16  colour shown when no task is active (paint or celebration path).
- active_onehot  out  N  one-hot selected task, for led[N-1:0].
- active_idx  out  $clog2(N)  index of selected task; 0 when none is selected.
- any_active  out  1  some task is selected.
- seg_en  out  1  7-segment enable; equals ~any_active, registered.
- blanking  out  1  blank interval in progress.
- oled_colour  out  16  pixel data to Oled_Display.

Behaviour:
- Decided interface: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values:
  - active_onehot = 0, active_idx = 0, any_active = 0, seg_en = 1, blanking = 0.
  - All debounce counters = 0, stable request vector = 0.
  - oled_colour follows default_colour combinationally.
- Synchroniser: each req bit passes through 2 flops on clk before debounce.
- Debounce, per channel, evaluated only on tick:
  - If the synchronised bit differs from the stable bit, increment that channel's counter.
  - Otherwise clear the counter.
  - When the counter reaches DEBOUNCE_TICKS, toggle the stable bit and clear the counter.
  - Any mismatch that clears before DEBOUNCE_TICKS leaves the stable bit unchanged.
- Priority: the candidate is the lowest-index set bit of the stable vector; if none is set, the candidate is NONE.
- State machine:
  - States: IDLE (no task), RUN (task k), BLANK.
  - IDLE or RUN: if the candidate differs from the committed selection, then on the next clk commit the candidate to active_onehot / active_idx / any_active / seg_en, load the frame counter with BLANK_FRAMES, and enter BLANK.
  - BLANK: decrement the counter on each frame_begin. When it reaches 0, go to RUN if a task is committed, else to IDLE.
  - A candidate change during BLANK commits the new candidate at once and reloads the counter. The blank period restarts with no intermediate state.
  - Transition from IDLE to IDLE never occurs. A candidate equal to the current selection takes no action.
- Outputs per state:
  - BLANK: blanking = 1, oled_colour = BLANK_COLOUR.
  - RUN: oled_colour = colour_in[active_idx] (combinational mux, no added latency).
  - IDLE: oled_colour = default_colour.
- Simultaneous events: frame_begin in the same cycle as a commit is ignored; the reload wins.
- active_onehot is always zero or one-hot; any_active equals the OR of active_onehot.
- Reset asserted mid-blank or mid-debounce clears everything immediately. Operation resumes from IDLE with no pending change.

Test Plan:
- Reset, then req = 0 held for 40 ticks -> state IDLE, seg_en = 1, oled_colour = default_colour (e.g. 16'hF800), active_onehot = 0.
- req[2] = 1 stable -> after 2 clk + 16 ticks active_onehot = 4'b0100, seg_en = 0, blanking = 1 with oled_colour = 0 for exactly 2 frame_begin pulses, then oled_colour = colour_in[47:32].
- req[2] and req[1] both debounced -> selection 4'b0010. Dropping req[1] returns the selection to channel 2 after 16 ticks plus a fresh 2-frame blank.
- Glitch on req[3] of 10 ticks, then low -> no selection change and blanking never asserts. A glitch of exactly 16 ticks is accepted.
- Change req from channel 2 to channel 3 after one blank frame -> counter reloads to 2, total blank = 3 frames, and active_idx becomes 3 immediately.
- Assert reset during BLANK with channel 0 selected -> same cycle: active_onehot = 0, blanking = 0, seg_en = 1. After release with req still high, re-acquisition takes 2 clk + 16 ticks.
